// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the pc_sequencer next-PC stage.
package pc_sequencer_pkg;

    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        JkNone,
        JkBr,
        JkJr,
        JkBalrz,
        JkJrsal,
        JkJmadd,
        JkBalmn
    } jump_kind_e;

    localparam logic [4:0]  LinkRegDefault = 5'd31;
    localparam logic [31:0] TrapOffset     = 32'h80;

    // Kinds whose target arrives from data memory rather than the datapath.
    function automatic logic is_mem_kind(jump_kind_e kind);
        return (kind == JkJrsal) || (kind == JkJmadd) || (kind == JkBalmn);
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Priority-encodes the decoder's flow-change strobes into a jump kind, a taken
// flag, a link request and the datapath target (memory targets are resolved later).
module pc_target_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PcWidth = 32
) (
    input  logic               branch_i,
    input  logic               balrz_i,
    input  logic               jr_i,
    input  logic               jrsal_i,
    input  logic               jmadd_i,
    input  logic               balmn_i,
    input  logic               alu_zero_i,
    input  logic               status_z_i,
    input  logic               status_n_i,
    input  logic [PcWidth-1:0] imm_ext_i,
    input  logic [PcWidth-1:0] rs_data_i,
    input  logic [PcWidth-1:0] pc_plus4_i,
    output jump_kind_e         kind_o,
    output logic               taken_o,
    output logic               link_o,
    output logic [PcWidth-1:0] target_o
);

    always_comb begin
        kind_o   = JkNone;
        taken_o  = 1'b0;
        link_o   = 1'b0;
        target_o = pc_plus4_i;
        if (jmadd_i) begin
            kind_o  = JkJmadd;
            taken_o = 1'b1;
        end else if (jrsal_i) begin
            kind_o  = JkJrsal;
            taken_o = 1'b1;
            link_o  = 1'b1;
        end else if (balmn_i) begin
            kind_o  = JkBalmn;
            taken_o = status_n_i;
            link_o  = status_n_i;
        end else if (balrz_i) begin
            kind_o  = JkBalrz;
            taken_o = status_z_i;
            link_o  = status_z_i;
            if (status_z_i) begin
                target_o = rs_data_i;
            end
        end else if (jr_i) begin
            kind_o   = JkJr;
            taken_o  = 1'b1;
            target_o = rs_data_i;
        end else if (branch_i) begin
            kind_o  = JkBr;
            taken_o = alu_zero_i;
            if (alu_zero_i) begin
                target_o = pc_plus4_i + (imm_ext_i << 2);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, Z/N status flags, memory-indirect wait FSM and $31 link write.
// Optional: PC_ALIGN_CHECK_EN traps misaligned targets and adds sticky align_err.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [4:0]          LINK_REG = LinkRegDefault
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic                balrz,
    input  logic                jr,
    input  logic                jrsal,
    input  logic                jmadd,
    input  logic                balmn,
    input  logic                alu_zero,
    input  logic                alu_neg,
    input  logic                flag_we,
    input  logic [PC_WIDTH-1:0] imm_ext,
    input  logic [PC_WIDTH-1:0] rs_data,
    input  logic [PC_WIDTH-1:0] mem_rdata,
    input  logic                mem_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                stall,
    output logic                link_we,
    output logic [4:0]          link_addr,
    output logic [PC_WIDTH-1:0] link_data,
    output logic                status_z,
`ifdef PC_ALIGN_CHECK_EN
    output logic                status_n,
    output logic                align_err
`else
    output logic                status_n
`endif
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                status_z_q, status_z_d;
    logic                status_n_q, status_n_d;
    logic                link_we_q, link_we_d;
    logic [PC_WIDTH-1:0] link_data_q, link_data_d;
    logic                pend_link_q, pend_link_d;

    jump_kind_e          mux_kind;
    logic                mux_taken;
    logic                mux_link;
    logic [PC_WIDTH-1:0] mux_target;

    logic                load;
    logic                load_link;
    logic [PC_WIDTH-1:0] load_pc;

    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    pc_target_mux #(
        .PcWidth (PC_WIDTH)
    ) u_target_mux (
        .branch_i   (branch),
        .balrz_i    (balrz),
        .jr_i       (jr),
        .jrsal_i    (jrsal),
        .jmadd_i    (jmadd),
        .balmn_i    (balmn),
        .alu_zero_i (alu_zero),
        .status_z_i (status_z_q),
        .status_n_i (status_n_q),
        .imm_ext_i  (imm_ext),
        .rs_data_i  (rs_data),
        .pc_plus4_i (pc_plus4),
        .kind_o     (mux_kind),
        .taken_o    (mux_taken),
        .link_o     (mux_link),
        .target_o   (mux_target)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_link_d = pend_link_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        status_z_d  = status_z_q;
        status_n_d  = status_n_q;
        stall       = 1'b0;
        load        = 1'b0;
        load_link   = 1'b0;
        load_pc     = pc_q;
`ifdef PC_ALIGN_CHECK_EN
        align_err_d = align_err_q;
`endif

        case (state_q)
            StRun: begin
                if (mux_taken && is_mem_kind(mux_kind)) begin
                    stall       = 1'b1;
                    state_d     = StWait;
                    pend_link_d = mux_link;
                end else begin
                    load      = 1'b1;
                    load_pc   = mux_target;
                    load_link = mux_link;
                end
            end
            StWait: begin
                stall = 1'b1;
                if (mem_valid) begin
                    load      = 1'b1;
                    load_pc   = mem_rdata;
                    load_link = pend_link_q;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (load) begin
`ifdef PC_ALIGN_CHECK_EN
            if (load_pc[1:0] != 2'b00) begin
                pc_d        = RESET_PC + PC_WIDTH'(TrapOffset);
                align_err_d = 1'b1;
                load_link   = 1'b0;
            end else begin
                pc_d = load_pc;
            end
`else
            pc_d = load_pc;
`endif
            // pc is held through WAIT, so pc_plus4 is still the linking instruction's.
            if (load_link) begin
                link_we_d   = 1'b1;
                link_data_d = pc_plus4;
            end
        end

        if (flag_we && !stall) begin
            status_z_d = alu_zero;
            status_n_d = alu_neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            status_z_q  <= 1'b0;
            status_n_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            pend_link_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            status_z_q  <= status_z_d;
            status_n_q  <= status_n_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            pend_link_q <= pend_link_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`endif

    assign pc        = pc_q;
    assign link_we   = link_we_q;
    assign link_addr = LINK_REG;
    assign link_data = link_data_q;
    assign status_z  = status_z_q;
    assign status_n  = status_n_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and link-write stage directly downstream of the main control decoder.
- Consumes the decoder's branch/jump strobes (branch, balrz, jr, jrsal, jmadd, balmn) and owns the PC register and the Z/N status-flag register.
- Resolves every flow-change instruction, including memory-indirect jumps, which take a multi-cycle wait on data memory.
- Produces the link write to $31 for the register file.

Parameters:
- PC_WIDTH, 32, width of PC, targets and link data.
- RESET_PC, 32'h0000_0000, PC value after reset.
- LINK_REG, 5'd31, register-file index written by linking instructions.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- branch  in  1  beq/bn strobe from decoder; taken when alu_zero=1.
- balrz  in  1  branch-and-link to rs_data if status_z=1.
- jr  in  1  jump to rs_data.
- jrsal  in  1  jump to mem_rdata and link, unconditional.
- jmadd  in  1  jump to mem_rdata, no link.
- balmn  in  1  branch-and-link to mem_rdata if status_n=1.
- alu_zero  in  1  ALU zero result of the current instruction.
- alu_neg  in  1  ALU result bit [PC_WIDTH-1] of the current instruction.
- flag_we  in  1  latch alu_zero/alu_neg into the status register.
- imm_ext  in  PC_WIDTH  sign-extended 16-bit immediate.
- rs_data  in  PC_WIDTH  register rs read data.
- mem_rdata  in  PC_WIDTH  data-memory read word.
- mem_valid  in  1  mem_rdata valid this cycle.
- pc  out  PC_WIDTH  current instruction address.
- pc_plus4  out  PC_WIDTH  pc+4, combinational.
- stall  out  1  pipeline hold; the decoder must keep the instruction stable.
- link_we  out  1  register-file write strobe for link, one cycle.
- link_addr  out  5  always LINK_REG.
- link_data  out  PC_WIDTH  registered return address.
- status_z  out  1  registered Z flag.
- status_n  out  1  registered N flag.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, status_z=0, status_n=0.
  - link_we=0, link_data=0, stall=0, state=RUN.
- Strobe priority (strobes should be one-hot; if several are high): jmadd > jrsal > balmn > balrz > jr > branch.
- State RUN, no memory-indirect op; the PC updates on the next rising edge:
  - branch & alu_zero -> pc <= pc_plus4 + (imm_ext<<2).
  - balrz & status_z -> pc <= rs_data, link.
  - jr -> pc <= rs_data.
  - balrz with status_z=0 behaves as a fall-through.
  - Otherwise pc <= pc_plus4.
- Arithmetic is modulo 2^PC_WIDTH; wrap from 32'hFFFF_FFFC to 0 is silent.
- Memory-indirect ops: jrsal, jmadd, and balmn with status_n=1.
  - RUN -> WAIT on the next edge; pc is held.
  - stall=1, combinationally, in the same cycle as the strobe and throughout WAIT.
  - balmn with status_n=0 falls through in one cycle, with no stall.
- State WAIT:
  - pc and flags are held; stall=1.
  - On a cycle with mem_valid=1: pc <= mem_rdata, the link (if any) is performed, and the state returns to RUN on that edge.
  - stall drops in the cycle after mem_valid.
  - mem_valid in RUN is ignored.
- Link: link_data <= registered pc_plus4 of the linking instruction; link_we=1 for exactly the one cycle after the PC update edge.
- Flags: status_z/status_n <= alu_zero/alu_neg on an edge when flag_we=1 and stall=0.
  - balrz and balmn test the registered flags, i.e. those of the previous flag-writing instruction.
  - flag_we during a stall is ignored.
- Reset during WAIT: the pending jump and link are discarded; link_we=0.

Optional Feature:
- PC_ALIGN_CHECK_EN defined:
  - Any computed target with [1:0]!=0 forces pc <= RESET_PC + 32'h80 (trap vector).
  - A sticky output align_err (1 bit, cleared by reset only) is set.
  - Any link for that instruction is suppressed.
- Undefined: no align_err port; misaligned targets are loaded verbatim.

Decomposition:
- Shared package:
  - State encoding RUN=1'b0, WAIT=1'b1.
  - LINK_REG default and trap-vector offset 32'h80.
  - Jump-kind codes: NONE, BR, JR, BALRZ, JRSAL, JMADD, BALMN.
- Sub-module pc_target_mux: combinational priority encode of the strobes into a jump kind plus target/link select. The top level holds the PC, flags, FSM and link registers.

Test Plan:
- Reset asserted mid-cycle, pc previously 32'h40 -> pc=0 immediately; flags and link_we=0; after release, pc steps 0, 4, 8.
- At pc=32'h10: branch=1, alu_zero=1, imm_ext=32'hFFFF_FFFE -> next pc=32'h0C; with alu_zero=0 -> 32'h14.
- Flag-writing instruction with alu_zero=1 (flag_we=1), then balrz with rs_data=32'h200 at pc=32'h20:
  - pc=32'h200; link_we pulses once with link_data=32'h24, link_addr=31.
  - Repeated with status_z=0: pc=32'h24, no link.
- jrsal at pc=32'h30, mem_valid withheld 3 cycles, then mem_rdata=32'h1000:
  - stall high 4 cycles, pc held at 32'h30, then pc=32'h1000.
  - link_data=32'h34; flag_we pulses during the stall do not change the flags.
- jmadd and jr asserted together, rs_data=32'h80, mem_rdata=32'h900 -> jmadd wins: pc=32'h900, no link_we.
- balmn in WAIT, reset asserted before mem_valid -> pc=0, no link_we. Then:
  - With PC_ALIGN_CHECK_EN, jr to 32'h102 -> pc=32'h80, align_err=1.
